// File: rtl/spi_cfg_master_if.sv
// spi_cfg_master_if
//   Bundles the request/config handshake, readback strobe and SPI pins of
//   the CC3200 config/readback master.
//   master modport: the SPI master's view (drives SPI pins, status, readback).
//   slave  modport: the requester/link-partner view (drives Start/config, MISO).
interface spi_cfg_master_if;
  logic       Start;
  logic [1:0] Zoom;
  logic [5:0] Gain;
  logic [7:0] Line_Num;
  logic       Busy;
  logic       Done;
  logic       SPI_CLK;
  logic       SPI_CS;
  logic       SPI_MOSI;
  logic       SPI_MISO;
  logic       Envelop;
  logic [7:0] Rd_Data;
  logic       Rd_Valid;
  logic [8:0] Rd_Index;

  modport master (
    input  Start, Zoom, Gain, Line_Num, SPI_MISO,
    output Busy, Done, SPI_CLK, SPI_CS, SPI_MOSI, Envelop,
           Rd_Data, Rd_Valid, Rd_Index
  );

  modport slave (
    output Start, Zoom, Gain, Line_Num, SPI_MISO,
    input  Busy, Done, SPI_CLK, SPI_CS, SPI_MOSI, Envelop,
           Rd_Data, Rd_Valid, Rd_Index
  );
endinterface

// File: rtl/spi_cfg_master.sv
// spi_cfg_master
//   SPI master for the CC3200 config/readback link. One transaction is an
//   Envelop strobe, a dummy frame, two config frames ({Zoom,Gain}, Line_Num)
//   and NUM_READ readback frames; every frame is 8 bits, MSB first.
// Ports
//   Clk  : system clock, all logic on posedge
//   Rst  : synchronous active-high reset
//   bus  : spi_cfg_master_if.master -- Start/Zoom/Gain/Line_Num in,
//          Busy/Done status, SPI_CLK/SPI_CS/SPI_MOSI out, SPI_MISO in,
//          Envelop strobe, Rd_Data/Rd_Valid/Rd_Index readback
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for Start, all SPI pins idle
// ENV   | Envelop high for CLK_DIV cycles, CS high
// GAP   | CS high for CS_GAP cycles before each frame
// SHIFT | CS low, 17 half-periods: low lead-in, 8 clocks, low trailer
// FIN   | Done pulse cycle, Busy already low, Start ignored
module spi_cfg_master #(
  parameter int CLK_DIV  = 4,
  parameter int CS_GAP   = 4,
  parameter int NUM_READ = 256
) (
  input  logic Clk,
  input  logic Rst,
  spi_cfg_master_if.master bus
);

  localparam int CNT_MAX = (CLK_DIV > CS_GAP) ? CLK_DIV : CS_GAP;
  localparam int CW      = $clog2(CNT_MAX);
  localparam logic [9:0] LAST_FRAME = 10'(NUM_READ + 2);

  typedef enum logic [2:0] {IDLE, ENV, GAP, SHIFT, FIN} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [4:0]    half;
  logic [9:0]    frame;
  logic [15:0]   cfg;
  logic [6:0]    tx_sr;
  logic [6:0]    rx_sr;
  logic [7:0]    tx_byte;

  logic       sclk_q, cs_q, mosi_q, env_q, busy_q, done_q, rdv_q;
  logic [7:0] rd_data_q;
  logic [8:0] rd_index_q;

  assign bus.SPI_CLK  = sclk_q;
  assign bus.SPI_CS   = cs_q;
  assign bus.SPI_MOSI = mosi_q;
  assign bus.Envelop  = env_q;
  assign bus.Busy     = busy_q;
  assign bus.Done     = done_q;
  assign bus.Rd_Valid = rdv_q;
  assign bus.Rd_Data  = rd_data_q;
  assign bus.Rd_Index = rd_index_q;

  always_comb begin
    tx_byte = 8'h00;
    case (frame)
      10'd1:   tx_byte = cfg[15:8];
      10'd2:   tx_byte = cfg[7:0];
      default: tx_byte = 8'h00;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state      <= IDLE;
      cnt        <= '0;
      half       <= '0;
      frame      <= '0;
      cfg        <= '0;
      tx_sr      <= '0;
      rx_sr      <= '0;
      sclk_q     <= 1'b0;
      cs_q       <= 1'b1;
      mosi_q     <= 1'b0;
      env_q      <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      rdv_q      <= 1'b0;
      rd_data_q  <= '0;
      rd_index_q <= '0;
    end else begin
      done_q <= 1'b0;
      rdv_q  <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.Start) begin
            cfg    <= {bus.Zoom, bus.Gain, bus.Line_Num};
            busy_q <= 1'b1;
            env_q  <= 1'b1;
            cnt    <= CW'(CLK_DIV - 1);
            state  <= ENV;
          end
        end
        ENV: begin
          if (cnt == '0) begin
            env_q <= 1'b0;
            frame <= '0;
            cnt   <= CW'(CS_GAP - 1);
            state <= GAP;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        GAP: begin
          if (cnt == '0) begin
            cs_q   <= 1'b0;
            mosi_q <= tx_byte[7];
            tx_sr  <= tx_byte[6:0];
            rx_sr  <= '0;
            half   <= 5'd1;
            cnt    <= CW'(CLK_DIV - 1);
            state  <= SHIFT;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        SHIFT: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else begin
            cnt <= CW'(CLK_DIV - 1);
            // Odd half-periods from 3 on are the low phases after a falling
            // edge; MISO is taken on their last cycle.
            if (half[0] && half != 5'd1)
              rx_sr <= {rx_sr[5:0], bus.SPI_MISO};
            if (half == 5'd17) begin
              cs_q   <= 1'b1;
              mosi_q <= 1'b0;
              sclk_q <= 1'b0;
              half   <= '0;
              if (frame >= 10'd3) begin
                rdv_q      <= 1'b1;
                rd_data_q  <= {rx_sr, bus.SPI_MISO};
                rd_index_q <= 9'(frame - 10'd3);
              end
              if (frame == LAST_FRAME) begin
                done_q <= 1'b1;
                busy_q <= 1'b0;
                state  <= FIN;
              end else begin
                frame <= frame + 10'd1;
                cnt   <= CW'(CS_GAP - 1);
                state <= GAP;
              end
            end else begin
              half   <= half + 5'd1;
              // Leaving an odd half enters a high phase; leaving an even
              // half is a falling edge, where MOSI moves to the next bit.
              sclk_q <= half[0];
              if (!half[0]) begin
                mosi_q <= tx_sr[6];
                tx_sr  <= {tx_sr[5:0], 1'b0};
              end
            end
          end
        end
        FIN: begin
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_cfg_master.sv
module tb_spi_cfg_master;

  logic Clk = 1'b0;
  logic Rst = 1'b1;
  always #5 Clk = ~Clk;

  logic       sel   = 1'b0;
  logic       start = 1'b0;
  logic [1:0] zoom  = '0;
  logic [5:0] gain  = '0;
  logic [7:0] line  = '0;
  logic       miso  = 1'b0;

  spi_cfg_master_if ifa();
  spi_cfg_master_if ifb();

  assign ifa.Start    = start & ~sel;
  assign ifa.Zoom     = zoom;
  assign ifa.Gain     = gain;
  assign ifa.Line_Num = line;
  assign ifa.SPI_MISO = miso;
  assign ifb.Start    = start & sel;
  assign ifb.Zoom     = zoom;
  assign ifb.Gain     = gain;
  assign ifb.Line_Num = line;
  assign ifb.SPI_MISO = miso;

  spi_cfg_master #(.CLK_DIV(4), .CS_GAP(4), .NUM_READ(4)) dut_a (
    .Clk(Clk), .Rst(Rst), .bus(ifa));
  spi_cfg_master #(.CLK_DIV(4), .CS_GAP(4), .NUM_READ(1)) dut_b (
    .Clk(Clk), .Rst(Rst), .bus(ifb));

  logic       m_cs, m_sclk, m_mosi, m_env, m_busy, m_done, m_rdv;
  logic [7:0] m_rdd;
  logic [8:0] m_rdi;
  assign m_cs   = sel ? ifb.SPI_CS   : ifa.SPI_CS;
  assign m_sclk = sel ? ifb.SPI_CLK  : ifa.SPI_CLK;
  assign m_mosi = sel ? ifb.SPI_MOSI : ifa.SPI_MOSI;
  assign m_env  = sel ? ifb.Envelop  : ifa.Envelop;
  assign m_busy = sel ? ifb.Busy     : ifa.Busy;
  assign m_done = sel ? ifb.Done     : ifa.Done;
  assign m_rdv  = sel ? ifb.Rd_Valid : ifa.Rd_Valid;
  assign m_rdd  = sel ? ifb.Rd_Data  : ifa.Rd_Data;
  assign m_rdi  = sel ? ifb.Rd_Index : ifa.Rd_Index;

  typedef struct {
    logic [1:0] zoom;
    logic [5:0] gain;
    logic [7:0] line;
    logic [7:0] exp_b1;
    logic [7:0] exp_b2;
  } vec_t;
  vec_t vecs[4];

  int total = 0;
  int bad   = 0;
  logic [7:0]  exp_mosi[$];
  logic [16:0] exp_rd[$];
  logic [7:0]  slave_bytes[4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Bus monitor and slave model, sampled on the falling Clk edge.
  logic mon_on = 1'b0;
  logic abort  = 1'b0;
  int cyc = 0, fall_cyc = 0, nfall = 0, rises = 0, sframe = 0, env_w = 0, done_cnt = 0;
  logic [7:0] mbyte = '0, sbyte = '0;
  logic p_cs = 1'b1, p_sclk = 1'b0, p_mosi = 1'b0, p_env = 1'b0;

  always @(negedge Clk) begin
    cyc++;
    if (mon_on) begin
      if (abort) begin
        env_w = 0;
      end else begin
        if (m_env) env_w++;
        else if (p_env) begin
          check("envelop_width", 32'(env_w), 32'd4);
          env_w = 0;
        end
        if (m_env && !p_env) begin
          sframe = 0;
          nfall  = 0;
        end
        if (!m_cs && p_cs) begin
          if (nfall > 0) check("frame_period", 32'(cyc - fall_cyc), 32'd72);
          fall_cyc = cyc;
          nfall++;
          rises = 0;
          mbyte = '0;
          sbyte = (sframe >= 3) ? slave_bytes[sframe-3] : 8'hEE;
        end
        if (m_sclk && !p_sclk) begin
          check("mosi_stable_at_rise", 32'(m_mosi), 32'(p_mosi));
          rises++;
          mbyte = {mbyte[6:0], m_mosi};
        end
        if (!m_sclk && p_sclk) begin
          miso  = sbyte[7];
          sbyte = {sbyte[6:0], 1'b0};
        end
        if (m_cs && !p_cs) begin
          check("sclk_rises", 32'(rises), 32'd8);
          if (exp_mosi.size() == 0) begin
            check("unexpected_frame", 32'(mbyte), 32'hFFFF_FFFF);
          end else begin
            check("mosi_byte", 32'(mbyte), 32'(exp_mosi.pop_front()));
          end
          sframe++;
        end
      end
      if (m_rdv) begin
        if (exp_rd.size() == 0) check("unexpected_rd_valid", {15'd0, m_rdi, m_rdd}, 32'hFFFF_FFFF);
        else check("rd_index_data", {15'd0, m_rdi, m_rdd}, {15'd0, exp_rd.pop_front()});
      end
      if (m_done) begin
        check("busy_low_in_done", 32'(m_busy), 32'd0);
        done_cnt++;
      end
    end
    p_cs = m_cs; p_sclk = m_sclk; p_mosi = m_mosi; p_env = m_env;
  end

  task automatic tick;
    @(posedge Clk);
    #1;
  endtask

  task automatic start_txn(input vec_t v, input int nr);
    zoom  = v.zoom;
    gain  = v.gain;
    line  = v.line;
    start = 1'b1;
    exp_mosi.push_back(8'h00);
    exp_mosi.push_back(v.exp_b1);
    exp_mosi.push_back(v.exp_b2);
    for (int i = 0; i < nr; i++) begin
      exp_mosi.push_back(8'h00);
      exp_rd.push_back({9'(i), slave_bytes[i]});
    end
    tick();
    start = 1'b0;
    check("busy_after_start", 32'(m_busy), 32'd1);
  endtask

  task automatic wait_done(input int budget);
    int n;
    n = 0;
    while (!m_done && n < budget) begin
      tick();
      n++;
    end
    check("done_seen", 32'(m_done), 32'd1);
  endtask

  task automatic drain_check;
    @(negedge Clk);
    #1;
    check("mosi_frames_left", 32'(exp_mosi.size()), 32'd0);
    check("rd_items_left", 32'(exp_rd.size()), 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_cs"},    32'(m_cs),   32'd1);
    check({tag, "_sclk"},  32'(m_sclk), 32'd0);
    check({tag, "_mosi"},  32'(m_mosi), 32'd0);
    check({tag, "_env"},   32'(m_env),  32'd0);
    check({tag, "_busy"},  32'(m_busy), 32'd0);
    check({tag, "_done"},  32'(m_done), 32'd0);
    check({tag, "_rdv"},   32'(m_rdv),  32'd0);
    check({tag, "_rdd"},   32'(m_rdd),  32'd0);
    check({tag, "_rdi"},   32'(m_rdi),  32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0, n;
    vecs[0] = '{2'b10, 6'h15, 8'h5A, 8'h95, 8'h5A};
    vecs[1] = '{2'b00, 6'h3F, 8'h00, 8'h3F, 8'h00};
    vecs[2] = '{2'b11, 6'h00, 8'hFF, 8'hC0, 8'hFF};
    vecs[3] = '{2'b01, 6'h2A, 8'hC3, 8'h6A, 8'hC3};
    slave_bytes = '{8'hA5, 8'h3C, 8'hFF, 8'h01};

    Rst = 1'b1;
    repeat (3) tick();
    check_reset_outputs("reset");
    Rst = 1'b0;
    tick();
    mon_on = 1'b1;

    // Config vectors on the NUM_READ=4 instance.
    d0 = done_cnt;
    for (int i = 0; i < 4; i++) begin
      start_txn(vecs[i], 4);
      wait_done(2000);
      drain_check();
      tick();
    end
    check("done_count_vectors", 32'(done_cnt - d0), 32'd4);

    // Start while busy and in the Done cycle.
    d0 = done_cnt;
    start_txn(vecs[0], 4);
    repeat (100) tick();
    zoom = 2'b01; gain = 6'h01; line = 8'h11;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("busy_held_mid_txn", 32'(m_busy), 32'd1);
    wait_done(2000);
    check("busy_in_done_cycle", 32'(m_busy), 32'd0);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("start_in_done_ignored", 32'(m_busy), 32'd0);
    repeat (20) tick();
    check("still_idle", 32'(m_busy), 32'd0);
    check("single_done", 32'(done_cnt - d0), 32'd1);
    check("q_after_ignored_start", 32'(exp_mosi.size() + exp_rd.size()), 32'd0);

    // Reset during frame 3, bit 4.
    start_txn(vecs[1], 4);
    n = 0;
    while (!(sframe == 3 && rises == 4) && n < 1000) begin
      tick();
      n++;
    end
    check("reached_frame3_bit4", 32'(sframe == 3 && rises == 4), 32'd1);
    abort = 1'b1;
    Rst = 1'b1;
    tick();
    check_reset_outputs("midrst");
    Rst = 1'b0;
    exp_mosi.delete();
    exp_rd.delete();
    d0 = done_cnt;
    repeat (30) tick();
    check("no_done_after_rst", 32'(done_cnt - d0), 32'd0);
    abort = 1'b0;
    start_txn(vecs[2], 4);
    wait_done(2000);
    drain_check();
    tick();

    // NUM_READ=1 instance, back-to-back transactions with different config.
    sel = 1'b1;
    tick();
    d0 = done_cnt;
    slave_bytes[0] = 8'h5C;
    start_txn(vecs[3], 1);
    wait_done(1000);
    drain_check();
    tick();
    slave_bytes[0] = 8'hC3;
    start_txn(vecs[0], 1);
    wait_done(1000);
    drain_check();
    check("b2b_done_count", 32'(done_cnt - d0), 32'd2);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
